// File: rtl/nbit_and_pkg.sv
// Shared ALU definitions: flag-vector layout and default operand width.
package nbit_and_pkg;

  // Default operand/result width used by every ALU function unit.
  localparam int unsigned alu_default_len = 4;

  // Condition flags, ordered n, z, c, v from MSB to LSB.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  // Flag state matching a zero result: only z is set.
  localparam alu_flags_t alu_flags_reset = '{n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0};

endpackage

// File: rtl/nbit_and_if.sv
// Operand/result bundle between an ALU function unit and its issuer.
interface nbit_and_if #(
  parameter int unsigned len = nbit_and_pkg::alu_default_len
) ();

  logic [len-1:0] a;
  logic [len-1:0] b;
  logic           in_valid;
  logic [len-1:0] response;
  logic           n;
  logic           c;
  logic           z;
  logic           v;
  logic           out_valid;

  // Issuer side: drives operands, observes result and flags.
  modport master (
    output a, b, in_valid,
    input  response, n, c, z, v, out_valid
  );

  // Function-unit side.
  modport slave (
    input  a, b, in_valid,
    output response, n, c, z, v, out_valid
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational NZCV generation for any len-bit ALU result.
// n and z are derived from the result; c and v come from the calling unit.
module alu_flag_gen
  import nbit_and_pkg::*;
#(
  parameter int unsigned len = alu_default_len
) (
  input  logic [len-1:0] result,
  input  logic           c,
  input  logic           v,
  output alu_flags_t     flags
);

  // Derive sign and zero from the result; forward carry/overflow unchanged.
  always_comb begin
    flags   = alu_flags_reset;
    flags.n = result[len-1];
    flags.z = ~|result;
    flags.c = c;
    flags.v = v;
  end

endmodule

// File: rtl/nbit_and.sv
// N-bit bitwise-AND ALU unit with NZCV flags and a single output register stage.
module nbit_and
  import nbit_and_pkg::*;
#(
  parameter int unsigned len = alu_default_len
) (
  input logic    clk,
  input logic    rst,
  nbit_and_if.slave bus
);

  logic [len-1:0] result_d;
  logic [len-1:0] response_q;
  alu_flags_t     flags_d;
  alu_flags_t     flags_q;
  logic           out_valid_q;

  // AND array: pure bitwise, no carries between bit positions.
  always_comb begin
    result_d = bus.a & bus.b;
  end

  // Logical op: carry and overflow are defined as zero.
  alu_flag_gen #(
    .len (len)
  ) u_flag_gen (
    .result (result_d),
    .c      (1'b0),
    .v      (1'b0),
    .flags  (flags_d)
  );

  // Output stage: capture on in_valid, otherwise hold data and drop out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      response_q  <= '0;
      flags_q     <= alu_flags_reset;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        response_q <= result_d;
        flags_q    <= flags_d;
      end
    end
  end

  assign bus.response  = response_q;
  assign bus.n         = flags_q.n;
  assign bus.z         = flags_q.z;
  assign bus.c         = flags_q.c;
  assign bus.v         = flags_q.v;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_nbit_and.sv
// Scoreboard bench for nbit_and at len=4.
module tb_nbit_and;

  typedef struct packed {
    logic [3:0] resp;
    logic       n;
    logic       z;
    logic       c;
    logic       v;
  } exp_t;

  localparam exp_t exp_reset = '{resp: 4'b0000, n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0};

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t last;

  nbit_and_if #(.len(4)) bus ();

  nbit_and #(
    .len (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] ta, input logic [3:0] tb);
    exp_t e;
    e.resp = ta & tb;
    e.n    = e.resp[3];
    e.z    = (e.resp == 4'd0);
    e.c    = 1'b0;
    e.v    = 1'b0;
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".response"}, {4'd0, bus.response}, {4'd0, e.resp});
    check({tag, ".n"}, {7'd0, bus.n}, {7'd0, e.n});
    check({tag, ".z"}, {7'd0, bus.z}, {7'd0, e.z});
    check({tag, ".c"}, {7'd0, bus.c}, {7'd0, e.c});
    check({tag, ".v"}, {7'd0, bus.v}, {7'd0, e.v});
  endtask

  // Called at posedge+1: drive inputs, push expectation, cross one edge, compare.
  task automatic step(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                      input logic tv);
    bus.a        = ta;
    bus.b        = tb;
    bus.in_valid = tv;
    if (tv) sb.push_back(model(ta, tb));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, {7'd0, bus.out_valid}, {7'd0, tv});
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        check({tag, ".sb_empty"}, 8'd1, 8'd0);
      end else begin
        last = sb.pop_front();
      end
    end
    check_outputs(tag, last);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    last         = exp_reset;
    rst          = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.in_valid = 1'b0;

    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b1;
    #1;
    check("rst.out_valid", {7'd0, bus.out_valid}, 8'd0);
    check_outputs("rst", exp_reset);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle.out_valid", {7'd0, bus.out_valid}, 8'd0);

    step("op_2_3", 4'd2, 4'd3, 1'b1);
    step("b2b_4_4", 4'd4, 4'd4, 1'b1);
    step("b2b_7_1", 4'd7, 4'd1, 1'b1);
    step("neg_8_12", 4'd8, 4'd12, 1'b1);
    step("zero_5_10", 4'd5, 4'd10, 1'b1);
    step("hold_15_15", 4'd15, 4'd15, 1'b0);
    step("neg2_14_11", 4'd14, 4'd11, 1'b1);
    step("hold2", 4'd0, 4'd0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end

    // Ensure out_valid=1 before the mid-stream reset.
    step("pre_rst_9_13", 4'd9, 4'd13, 1'b1);
    bus.a        = 4'd15;
    bus.b        = 4'd15;
    bus.in_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    sb.delete();
    last = exp_reset;
    check("midrst.out_valid", {7'd0, bus.out_valid}, 8'd0);
    check_outputs("midrst", exp_reset);
    // in_valid held high across an edge while in reset must be ignored.
    @(posedge clk);
    #1;
    check("rsthold.out_valid", {7'd0, bus.out_valid}, 8'd0);
    check_outputs("rsthold", exp_reset);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step("post_rst_idle", 4'd15, 4'd15, 1'b0);
    step("post_rst_6_3", 4'd6, 4'd3, 1'b1);
    step("post_rst_15_15", 4'd15, 4'd15, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
